// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard scoreboard: in-flight entry layout,
// forwarding-select encoding and result-ready stage constants.
package hazard_pkg;

    localparam int ENT_AW  = 8;
    localparam int ENT_RSW = 4;

    typedef struct packed {
        logic               valid;
        logic [ENT_AW-1:0]  addr;
        logic [ENT_RSW-1:0] rdy;
    } ent_t;

    localparam int SEL_RF  = 0;
    localparam int RDY_EXE = 0;
    localparam int RDY_MEM = 1;

    function automatic int SEL_STAGE(input int i);
        return i + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage bundle between decode/control and the hazard scoreboard: decoded
// operands and destination, pipeline controls, stage results and the stall/forward answer.
interface hazard_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int STAGES = 3,
    parameter int NSRC   = 2
);
    import hazard_pkg::*;

    localparam int AW   = $clog2(NREG);
    localparam int RSW  = $clog2(STAGES);
    localparam int SELW = $clog2(STAGES + 1);

    logic                    id_valid;
    logic [NSRC-1:0]         id_src_used;
    logic [NSRC*AW-1:0]      id_src_addr;
    logic                    id_dst_wen;
    logic [AW-1:0]           id_dst_addr;
    logic [RSW-1:0]          id_ready_stage;
    logic                    id_kill;
    logic                    hold;
    logic                    flush_all;
    logic [STAGES*XLEN-1:0]  stage_data;
    logic [NSRC*XLEN-1:0]    rf_data;
    logic                    stall;
    logic [NSRC*SELW-1:0]    fwd_sel;
    logic [NSRC*XLEN-1:0]    opnd;

    modport master (
        output id_valid, id_src_used, id_src_addr, id_dst_wen, id_dst_addr,
               id_ready_stage, id_kill, hold, flush_all, stage_data, rf_data,
        input  stall, fwd_sel, opnd
    );

    modport slave (
        input  id_valid, id_src_used, id_src_addr, id_dst_wen, id_dst_addr,
               id_ready_stage, id_kill, hold, flush_all, stage_data, rf_data,
        output stall, fwd_sel, opnd
    );

endinterface

// File: rtl/hazard_scoreboard_fwd_src_lookup.sv
// Per-source priority match against the in-flight scoreboard plus operand mux.
// HAZARD_FWD_EN selects full forwarding; undefined gives a pure interlock.
module fwd_src_lookup
    import hazard_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int SELW   = 2
) (
    input  logic                   used,
    input  logic [AW-1:0]          addr,
    input  ent_t [STAGES-1:0]      ent,
    input  logic [STAGES*XLEN-1:0] stage_data,
    input  logic [XLEN-1:0]        rf_data,
    output logic [SELW-1:0]        sel,
    output logic                   hazard,
    output logic [XLEN-1:0]        opnd
);

    logic found;

    // The youngest writer (lowest index) wins; once found, older entries are ignored.
    always_comb begin
        sel    = SELW'(SEL_RF);
        hazard = 1'b0;
        found  = 1'b0;
        if (used && addr != '0) begin
            for (int i = 0; i < STAGES; i++) begin
                if (!found && ent[i].valid && ent[i].addr == ENT_AW'(addr)) begin
                    found = 1'b1;
`ifdef HAZARD_FWD_EN
                    if (i >= int'(ent[i].rdy))
                        sel = SELW'(SEL_STAGE(i));
                    else
                        hazard = 1'b1;
`else
                    hazard = 1'b1;
`endif
                end
            end
        end
    end

`ifndef HAZARD_FWD_EN
    logic unused_rdy;

    always_comb begin
        unused_rdy = 1'b0;
        for (int i = 0; i < STAGES; i++)
            unused_rdy = unused_rdy ^ (^ent[i].rdy);
    end
`endif

    always_comb begin
        opnd = rf_data;
        for (int i = 0; i < STAGES; i++) begin
            if (sel == SELW'(SEL_STAGE(i)))
                opnd = stage_data[i*XLEN +: XLEN];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with per-source
// forwarding select, forwarded operand and a single ID stall request.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int STAGES = 3,
    parameter int NSRC   = 2
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam int AW   = $clog2(NREG);
    localparam int SELW = $clog2(STAGES + 1);

    ent_t [STAGES-1:0]     ent;
    ent_t                  new_ent;
    logic [NSRC-1:0]       hazard;
    logic                  issue;
    logic [NSRC*SELW-1:0]  sel_vec;
    logic [NSRC*XLEN-1:0]  opnd_vec;

    assign bus.stall   = bus.id_valid & ~bus.id_kill & (|hazard);
    assign issue       = bus.id_valid & ~bus.id_kill & ~bus.stall;
    assign bus.fwd_sel = sel_vec;
    assign bus.opnd    = opnd_vec;

    // Writes to r0 are never tracked, so r0 readers always fall through to the RF.
    always_comb begin
        new_ent = '0;
        if (issue && bus.id_dst_wen && bus.id_dst_addr != '0) begin
            new_ent.valid = 1'b1;
            new_ent.addr  = ENT_AW'(bus.id_dst_addr);
            new_ent.rdy   = ENT_RSW'(bus.id_ready_stage);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent <= '0;
        end else if (bus.flush_all) begin
            ent <= '0;
        end else if (!bus.hold) begin
            ent[0] <= new_ent;
            for (int i = 1; i < STAGES; i++)
                ent[i] <= ent[i-1];
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_src_lookup #(
            .XLEN   (XLEN),
            .STAGES (STAGES),
            .AW     (AW),
            .SELW   (SELW)
        ) u_lookup (
            .used       (bus.id_src_used[s]),
            .addr       (bus.id_src_addr[s*AW +: AW]),
            .ent        (ent),
            .stage_data (bus.stage_data),
            .rf_data    (bus.rf_data[s*XLEN +: XLEN]),
            .sel        (sel_vec[s*SELW +: SELW]),
            .hazard     (hazard[s]),
            .opnd       (opnd_vec[s*XLEN +: XLEN])
        );
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding block for the in-order MIPS pipeline. It generalises the fixed EXE/MEM bypass to `STAGES` tracked post-ID stages and `NSRC` source operands, each in-flight writer carrying its own result-ready stage. It keeps a shift-register scoreboard of in-flight destination registers and, in ID, produces for every source a forwarding select, the forwarded operand and a single stall request. It sits between decode/control and the ID-stage operand registers.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREG`, 32: architectural registers; `AW = $clog2(NREG)`.
- `STAGES`, 3: tracked stages after ID (index 0 = EXE … `STAGES-1` = WB).
- `NSRC`, 2: source operands per instruction.
- Derived: `RSW = $clog2(STAGES)`, `SELW = $clog2(STAGES+1)`.

Ports (all stage-indexed buses are packed with element 0 at the LSBs):
- `clk` in 1: clock; one clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_src_used` in NSRC: source s is read.
- `id_src_addr` in NSRC*AW: source register numbers.
- `id_dst_wen` in 1: instruction writes a register.
- `id_dst_addr` in AW: destination register.
- `id_ready_stage` in RSW: first stage index whose output carries the result (ALU 0, load 1).
- `id_kill` in 1: ID instruction squashed (branch in ID); treated as bubble.
- `hold` in 1: global pipeline freeze (memory wait); scoreboard keeps its state.
- `flush_all` in 1: invalidate every entry.
- `stage_data` in STAGES*XLEN: result value at each stage output.
- `rf_data` in NSRC*XLEN: register-file read data.
- `stall` out 1: ID must not advance; EXE receives a bubble.
- `fwd_sel` out NSRC*SELW: 0 = register file, 1+i = `stage_data[i]`.
- `opnd` out NSRC*XLEN: selected operand.

## Operation
- Entry i holds {valid, addr, rdy}. Only writers with `id_dst_wen=1` and `id_dst_addr!=0` are allocated.
- Lookup per source:
  - Ignore the source if it is unused or its address is 0; select RF.
  - Otherwise take the youngest (lowest i) valid entry with a matching addr.
  - If `i >= rdy`, select `1+i`.
  - If `i < rdy`, set `hazard_s`.
  - If no entry matches, select RF.
- `stall = id_valid & ~id_kill & |hazard_s`.
- `issue = id_valid & ~id_kill & ~stall`.
- Advance when `hold=0`:
  - `ent[0] <= issue ? new : invalid`.
  - `ent[i] <= ent[i-1]`.
  - The WB entry retires.
- When `hold=1`, all entries keep their values.
- The register file is not write-through, so a WB-stage entry must still forward.
- `opnd` is driven from `fwd_sel` in every case, including while `stall=1`; consumers must ignore it when stalled.

## Timing
- `stall`, `fwd_sel` and `opnd` are combinational from scoreboard state and ID inputs (zero latency). The scoreboard updates on posedge `clk`.
- Reset (`rst_n=0` at an edge): all entries invalid. Outputs are then `stall=0` and `fwd_sel=0` for every source. If `rst_n` is asserted mid-operation, entries are cleared at that edge regardless of `hold`.
- Precedence per edge: `rst_n` > `flush_all` > `hold` > advance.
- Load-use stall with `rdy=1`: one cycle. A producer with `rdy=r` followed immediately by a consumer stalls `r` cycles, plus any `hold` cycles.
- With `id_kill=1`, `stall` is forced to 0 and a bubble is inserted.

## Configuration
- `HAZARD_FWD_EN` defined: full forwarding as above.
- `HAZARD_FWD_EN` undefined:
  - Any match sets `hazard_s`; `fwd_sel` is always 0.
  - The consumer stalls until the producer retires from entry `STAGES-1` (pure interlock).

## Structure
- Package `hazard_pkg`:
  - entry struct typedef;
  - `SEL_RF` constant (0);
  - the `SEL_STAGE(i)` encoding;
  - ready-stage constants `RDY_EXE=0`, `RDY_MEM=1`.
- Sub-module `fwd_src_lookup`, instantiated NSRC times: priority match plus operand mux for one source. It outputs `sel`, `hazard` and `opnd`.

## Test plan
Defaults apply (STAGES=3, XLEN=32).
1. `add r3` issued, then `add r4,r3,r0` next cycle with `stage_data[0]=0x1234` -> `stall=0`, `fwd_sel[0]=1`, `opnd[0]=0x1234`.
2. `lw r5` (`rdy=1`), then `add r6,r5` -> `stall=1` for one cycle with a bubble in EXE; next cycle `fwd_sel=2` and `opnd=stage_data[1]=0xCAFE0000`.
3. r7 in EXE (0x11) and in MEM (0x22), consumer reads r7 -> `fwd_sel=1`, `opnd=0x11`. Consumer reads r7 on both sources -> both select EXE.
4. Writer `id_dst_addr=0` with `wen=1`, then consumer of r0 -> no allocation, `fwd_sel=0`, `opnd=rf_data`.
5. Load in EXE plus `hold=1` for 3 cycles -> `stall` stays 1 and entries are unchanged. Then `flush_all=1` together with `hold=1` -> scoreboard empty next cycle and `stall=0`.
6. Without `HAZARD_FWD_EN`, scenario 1 -> `stall=1` for 3 cycles, then `fwd_sel=0`. `rst_n=0` mid-stall -> `stall=0` after that edge.
